// File: rtl/watch_time_core.sv
// watch_time_core
// Watch / stopwatch / countdown datapath. An internal prescaler turns the
// system clock into a 100Hz tick that drives a msec -> sec -> min -> hour
// cascade, either counting up (clock/stopwatch) or down (countdown timer).
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-high
//   run_toggle  1-cycle pulse, start/stop
//   clear       1-cycle pulse, zero all fields and stop
//   dir         0 = count up, 1 = count down
//   adj_inc     1-cycle pulses, [0]=sec [1]=min [2]=hour, +1 with wrap
//   adj_dec     1-cycle pulses, same mapping, -1 with wrap
//   msec/sec/min/hour   time fields
//   running     high while in RUN
//   expired     high while in EXPIRED
//   done        1-cycle pulse on entry to EXPIRED
//   sec_tick    1-cycle pulse after msec carries/borrows into sec
module watch_time_core #(
   parameter int COUNT_100HZ = 1_000_000,
   parameter int MSEC_MAX    = 100,
   parameter int SEC_MAX     = 60,
   parameter int MIN_MAX     = 60,
   parameter int HOUR_MAX    = 24
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         run_toggle,
   input  logic                         clear,
   input  logic                         dir,
   input  logic [2:0]                   adj_inc,
   input  logic [2:0]                   adj_dec,
   output logic [$clog2(MSEC_MAX)-1:0]  msec,
   output logic [$clog2(SEC_MAX)-1:0]   sec,
   output logic [$clog2(MIN_MAX)-1:0]   min,
   output logic [$clog2(HOUR_MAX)-1:0]  hour,
   output logic                         running,
   output logic                         expired,
   output logic                         done,
   output logic                         sec_tick
);

   localparam int PW = (COUNT_100HZ > 1) ? $clog2(COUNT_100HZ) : 1;
   localparam int MW = $clog2(MSEC_MAX);
   localparam int SW = $clog2(SEC_MAX);
   localparam int NW = $clog2(MIN_MAX);
   localparam int HW = $clog2(HOUR_MAX);

   localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_100HZ - 1);
   localparam logic [MW-1:0] MSEC_LAST  = MW'(MSEC_MAX - 1);
   localparam logic [SW-1:0] SEC_LAST   = SW'(SEC_MAX - 1);
   localparam logic [NW-1:0] MIN_LAST   = NW'(MIN_MAX - 1);
   localparam logic [HW-1:0] HOUR_LAST  = HW'(HOUR_MAX - 1);

   localparam logic [1:0] ST_STOP = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_EXP  = 2'd2;

   logic [1:0]    r_state;
   logic [PW-1:0] r_presc;
   logic [MW-1:0] r_msec;
   logic [SW-1:0] r_sec;
   logic [NW-1:0] r_min;
   logic [HW-1:0] r_hour;
   logic          r_done;
   logic          r_secTick;

   logic          w_tick;
   logic          w_allZero;
   logic          w_holdZero;
   logic [2:0]    w_adjOn;
   logic [MW-1:0] w_msecUp, w_msecDn, w_msecNext;
   logic [SW-1:0] w_secUp,  w_secDn,  w_secNext;
   logic [NW-1:0] w_minUp,  w_minDn,  w_minNext;
   logic [HW-1:0] w_hourUp, w_hourDn, w_hourNext;
   logic          w_msecCarry, w_secCarry, w_minCarry;
   logic [PW-1:0] w_prescNext;
   logic [1:0]    w_stateNext;

   // Wrapped +1/-1 for every field; both adjust and the cascade pick from these.
   // Each compares against its own MAX-1 so non-power-of-two moduli wrap correctly.
   always_comb begin
      w_msecUp = (r_msec == MSEC_LAST) ? '0 : r_msec + MW'(1);
      w_msecDn = (r_msec == '0) ? MSEC_LAST : r_msec - MW'(1);
      w_secUp  = (r_sec == SEC_LAST) ? '0 : r_sec + SW'(1);
      w_secDn  = (r_sec == '0) ? SEC_LAST : r_sec - SW'(1);
      w_minUp  = (r_min == MIN_LAST) ? '0 : r_min + NW'(1);
      w_minDn  = (r_min == '0) ? MIN_LAST : r_min - NW'(1);
      w_hourUp = (r_hour == HOUR_LAST) ? '0 : r_hour + HW'(1);
      w_hourDn = (r_hour == '0) ? HOUR_LAST : r_hour - HW'(1);
   end

   // Tick qualification and adjust enables. A run_toggle on the tick edge wins
   // and suppresses the tick; adjust is locked out while expired, and pressing
   // inc and dec of the same field together cancels out.
   always_comb begin
      w_tick     = (r_state == ST_RUN) && !run_toggle && (r_presc == PRESC_LAST);
      w_allZero  = (r_msec == '0) && (r_sec == '0) && (r_min == '0) && (r_hour == '0);
      w_holdZero = w_tick && dir && w_allZero;
      w_adjOn    = (r_state != ST_EXP) ? (adj_inc ^ adj_dec) : 3'b000;
   end

   // Cascade. A field being adjusted takes only the adjust result, swallows the
   // incoming carry/borrow and so does not pass one on either. Counting down
   // from all-zero (reachable by adjusting) expires instead of wrapping.
   always_comb begin
      w_msecNext  = r_msec;
      w_secNext   = r_sec;
      w_minNext   = r_min;
      w_hourNext  = r_hour;
      w_msecCarry = 1'b0;
      w_secCarry  = 1'b0;
      w_minCarry  = 1'b0;

      if (w_tick && !w_holdZero) begin
         w_msecNext  = dir ? w_msecDn : w_msecUp;
         w_msecCarry = dir ? (r_msec == '0) : (r_msec == MSEC_LAST);
      end

      if (w_adjOn[0]) begin
         w_secNext = adj_inc[0] ? w_secUp : w_secDn;
      end else if (w_msecCarry) begin
         w_secNext  = dir ? w_secDn : w_secUp;
         w_secCarry = dir ? (r_sec == '0) : (r_sec == SEC_LAST);
      end

      if (w_adjOn[1]) begin
         w_minNext = adj_inc[1] ? w_minUp : w_minDn;
      end else if (w_secCarry) begin
         w_minNext  = dir ? w_minDn : w_minUp;
         w_minCarry = dir ? (r_min == '0) : (r_min == MIN_LAST);
      end

      if (w_adjOn[2]) begin
         w_hourNext = adj_inc[2] ? w_hourUp : w_hourDn;
      end else if (w_minCarry) begin
         w_hourNext = dir ? w_hourDn : w_hourUp;
      end
   end

   // Run control and prescaler. The prescaler only advances while running and
   // is held otherwise so a stop/start keeps the 10ms phase. Expiry is decided
   // on the post-tick field values.
   always_comb begin
      w_stateNext = r_state;
      w_prescNext = r_presc;

      if ((r_state == ST_RUN) && !run_toggle) begin
         w_prescNext = (r_presc == PRESC_LAST) ? '0 : r_presc + PW'(1);
      end

      case (r_state)
         ST_STOP: begin
            if (run_toggle && !(dir && w_allZero)) begin
               w_stateNext = ST_RUN;
            end
         end
         ST_RUN: begin
            if (run_toggle) begin
               w_stateNext = ST_STOP;
            end else if (w_tick && dir && (w_msecNext == '0) && (w_secNext == '0)
                         && (w_minNext == '0) && (w_hourNext == '0)) begin
               w_stateNext = ST_EXP;
            end
         end
         ST_EXP: begin
            if (run_toggle) begin
               w_stateNext = ST_STOP;
            end
         end
         default: w_stateNext = ST_STOP;
      endcase
   end

   // State registers. Clear outranks everything except reset and returns the
   // block to its reset picture, including the prescaler phase.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= ST_STOP;
         r_presc   <= '0;
         r_msec    <= '0;
         r_sec     <= '0;
         r_min     <= '0;
         r_hour    <= '0;
         r_done    <= 1'b0;
         r_secTick <= 1'b0;
      end else if (clear) begin
         r_state   <= ST_STOP;
         r_presc   <= '0;
         r_msec    <= '0;
         r_sec     <= '0;
         r_min     <= '0;
         r_hour    <= '0;
         r_done    <= 1'b0;
         r_secTick <= 1'b0;
      end else begin
         r_state   <= w_stateNext;
         r_presc   <= w_prescNext;
         r_msec    <= w_msecNext;
         r_sec     <= w_secNext;
         r_min     <= w_minNext;
         r_hour    <= w_hourNext;
         r_done    <= (r_state == ST_RUN) && (w_stateNext == ST_EXP);
         r_secTick <= w_msecCarry;
      end
   end

   assign msec     = r_msec;
   assign sec      = r_sec;
   assign min      = r_min;
   assign hour     = r_hour;
   assign running  = (r_state == ST_RUN);
   assign expired  = (r_state == ST_EXP);
   assign done     = r_done;
   assign sec_tick = r_secTick;

endmodule

// File: tb/tb_watch_time_core.sv
// tb_watch_time_core
// Directed bench for watch_time_core with a 4-cycle prescaler, so one msec
// step takes 4 clocks and one second takes 400 clocks.
module tb_watch_time_core;

   logic       clk;
   logic       reset;
   logic       run_toggle;
   logic       clear;
   logic       dir;
   logic [2:0] adj_inc;
   logic [2:0] adj_dec;
   logic [6:0] msec;
   logic [5:0] sec;
   logic [5:0] min;
   logic [4:0] hour;
   logic       running;
   logic       expired;
   logic       done;
   logic       sec_tick;

   int total;
   int bad;

   watch_time_core #(
      .COUNT_100HZ(4),
      .MSEC_MAX(100),
      .SEC_MAX(60),
      .MIN_MAX(60),
      .HOUR_MAX(24)
   ) dut (
      .clk(clk),
      .reset(reset),
      .run_toggle(run_toggle),
      .clear(clear),
      .dir(dir),
      .adj_inc(adj_inc),
      .adj_dec(adj_dec),
      .msec(msec),
      .sec(sec),
      .min(min),
      .hour(hour),
      .running(running),
      .expired(expired),
      .done(done),
      .sec_tick(sec_tick)
   );

   // Free-running clock; stimulus is driven and sampled on the falling edge.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic waitClk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic doReset();
      reset = 1'b1;
      run_toggle = 1'b0; clear = 1'b0; dir = 1'b0;
      adj_inc = 3'b000; adj_dec = 3'b000;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic pulseRun();
      run_toggle = 1'b1;
      @(negedge clk);
      run_toggle = 1'b0;
   endtask

   task automatic pulseClear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   task automatic pulseAdj(input logic [2:0] inc, input logic [2:0] dec);
      adj_inc = inc; adj_dec = dec;
      @(negedge clk);
      adj_inc = 3'b000; adj_dec = 3'b000;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      run_toggle = 1'b0; clear = 1'b0; dir = 1'b0;
      adj_inc = 3'b000; adj_dec = 3'b000;
      @(negedge clk);
      total++; if ({hour, min, sec, msec} !== 24'd0) begin bad++; $display("[TB] FAIL reset_fields got=%0d:%0d:%0d.%0d want=0:0:0.0", hour, min, sec, msec); end
      total++; if ({running, expired, done, sec_tick} !== 4'b0000) begin bad++; $display("[TB] FAIL reset_flags got=%b want=0000", {running, expired, done, sec_tick}); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_count_up_second();
      int pulses;
      doReset();
      pulseRun();
      pulses = 0;
      for (int i = 0; i < 400; i++) begin
         waitClk(1);
         pulses += int'(sec_tick);
         if (i == 199) begin
            total++; if (msec !== 7'd50) begin bad++; $display("[TB] FAIL up_mid_msec got=%0d want=50", msec); end
         end
      end
      total++; if (sec !== 6'd1 || msec !== 7'd0) begin bad++; $display("[TB] FAIL up_1s got=%0d.%0d want=1.0", sec, msec); end
      total++; if (pulses !== 1 || sec_tick !== 1'b1) begin bad++; $display("[TB] FAIL up_sec_tick got pulses=%0d now=%b want 1/1", pulses, sec_tick); end
      total++; if (running !== 1'b1) begin bad++; $display("[TB] FAIL up_running got=%b want=1", running); end
      waitClk(1);
      total++; if (sec_tick !== 1'b0) begin bad++; $display("[TB] FAIL up_sec_tick_drop got=%b want=0", sec_tick); end
   endtask

   task automatic test_full_rollover();
      doReset();
      pulseAdj(3'b000, 3'b001);
      pulseAdj(3'b000, 3'b010);
      pulseAdj(3'b000, 3'b100);
      total++; if (hour !== 5'd23 || min !== 6'd59 || sec !== 6'd59 || msec !== 7'd0) begin bad++; $display("[TB] FAIL adj_dec_wrap got=%0d:%0d:%0d.%0d want=23:59:59.0", hour, min, sec, msec); end
      pulseAdj(3'b001, 3'b001);
      total++; if (sec !== 6'd59) begin bad++; $display("[TB] FAIL adj_both_cancel got=%0d want=59", sec); end
      pulseRun();
      waitClk(396);
      total++; if (hour !== 5'd23 || min !== 6'd59 || sec !== 6'd59 || msec !== 7'd99) begin bad++; $display("[TB] FAIL rollover_pre got=%0d:%0d:%0d.%0d want=23:59:59.99", hour, min, sec, msec); end
      waitClk(4);
      total++; if ({hour, min, sec, msec} !== 24'd0) begin bad++; $display("[TB] FAIL rollover_zero got=%0d:%0d:%0d.%0d want=0:0:0.0", hour, min, sec, msec); end
      total++; if (running !== 1'b1 || expired !== 1'b0 || sec_tick !== 1'b1) begin bad++; $display("[TB] FAIL rollover_flags got run=%b exp=%b st=%b want 1/0/1", running, expired, sec_tick); end
      pulseRun();
   endtask

   task automatic test_countdown_expire();
      doReset();
      dir = 1'b1;
      pulseAdj(3'b001, 3'b000);
      pulseRun();
      waitClk(4);
      total++; if (sec !== 6'd0 || msec !== 7'd99 || sec_tick !== 1'b1) begin bad++; $display("[TB] FAIL down_first got=%0d.%0d st=%b want=0.99 st=1", sec, msec, sec_tick); end
      waitClk(392);
      total++; if (msec !== 7'd1 || running !== 1'b1 || expired !== 1'b0 || done !== 1'b0) begin bad++; $display("[TB] FAIL down_pre got msec=%0d run=%b exp=%b done=%b want 1/1/0/0", msec, running, expired, done); end
      waitClk(4);
      total++; if (done !== 1'b1 || expired !== 1'b1 || running !== 1'b0) begin bad++; $display("[TB] FAIL down_expire got done=%b exp=%b run=%b want 1/1/0", done, expired, running); end
      total++; if ({hour, min, sec, msec} !== 24'd0) begin bad++; $display("[TB] FAIL down_expire_fields got=%0d:%0d:%0d.%0d want=0", hour, min, sec, msec); end
      waitClk(1);
      total++; if (done !== 1'b0 || expired !== 1'b1) begin bad++; $display("[TB] FAIL down_done_pulse got done=%b exp=%b want 0/1", done, expired); end
      pulseAdj(3'b111, 3'b000);
      total++; if ({hour, min, sec, msec} !== 24'd0) begin bad++; $display("[TB] FAIL expired_adj_ignored got=%0d:%0d:%0d.%0d want=0", hour, min, sec, msec); end
      pulseRun();
      total++; if (expired !== 1'b0 || running !== 1'b0) begin bad++; $display("[TB] FAIL expired_exit got exp=%b run=%b want 0/0", expired, running); end
      dir = 1'b0;
   endtask

   task automatic test_adjust_on_tick();
      doReset();
      repeat (5) pulseAdj(3'b010, 3'b000);
      pulseAdj(3'b000, 3'b001);
      pulseRun();
      waitClk(396);
      total++; if (min !== 6'd5 || sec !== 6'd59 || msec !== 7'd99) begin bad++; $display("[TB] FAIL adjtick_pre got=%0d:%0d.%0d want=5:59.99", min, sec, msec); end
      waitClk(3);
      adj_inc = 3'b010;
      @(negedge clk);
      adj_inc = 3'b000;
      total++; if (hour !== 5'd0 || min !== 6'd6 || sec !== 6'd0 || msec !== 7'd0) begin bad++; $display("[TB] FAIL adjtick_carry_drop got=%0d:%0d:%0d.%0d want=0:6:0.0", hour, min, sec, msec); end
      pulseRun();
   endtask

   task automatic test_down_borrow();
      doReset();
      dir = 1'b1;
      pulseAdj(3'b100, 3'b000);
      pulseRun();
      waitClk(4);
      total++; if (hour !== 5'd0 || min !== 6'd59 || sec !== 6'd59 || msec !== 7'd99) begin bad++; $display("[TB] FAIL down_borrow got=%0d:%0d:%0d.%0d want=0:59:59.99", hour, min, sec, msec); end
      total++; if (running !== 1'b1 || expired !== 1'b0) begin bad++; $display("[TB] FAIL down_borrow_flags got run=%b exp=%b want 1/0", running, expired); end
      pulseRun();
      dir = 1'b0;
   endtask

   task automatic test_clear_and_reset();
      doReset();
      pulseRun();
      waitClk(10);
      total++; if (msec !== 7'd2) begin bad++; $display("[TB] FAIL clr_pre got=%0d want=2", msec); end
      pulseClear();
      total++; if (msec !== 7'd0 || running !== 1'b0) begin bad++; $display("[TB] FAIL clr_state got msec=%0d run=%b want 0/0", msec, running); end
      pulseRun();
      waitClk(3);
      total++; if (msec !== 7'd0) begin bad++; $display("[TB] FAIL clr_presc_phase got=%0d want=0", msec); end
      waitClk(1);
      total++; if (msec !== 7'd1) begin bad++; $display("[TB] FAIL clr_resume got=%0d want=1", msec); end
      waitClk(5);
      reset = 1'b1;
      #1;
      total++; if (msec !== 7'd0 || running !== 1'b0) begin bad++; $display("[TB] FAIL async_reset got msec=%0d run=%b want 0/0", msec, running); end
      @(negedge clk);
      reset = 1'b0;
      pulseRun();
      waitClk(3);
      total++; if (msec !== 7'd0) begin bad++; $display("[TB] FAIL rst_presc_phase got=%0d want=0", msec); end
      waitClk(1);
      total++; if (msec !== 7'd1) begin bad++; $display("[TB] FAIL rst_resume got=%0d want=1", msec); end
      pulseRun();
   endtask

   task automatic test_stop_resume();
      doReset();
      pulseRun();
      waitClk(6);
      pulseRun();
      total++; if (running !== 1'b0 || msec !== 7'd1) begin bad++; $display("[TB] FAIL stop got run=%b msec=%0d want 0/1", running, msec); end
      waitClk(5);
      total++; if (msec !== 7'd1) begin bad++; $display("[TB] FAIL stop_hold got=%0d want=1", msec); end
      pulseRun();
      waitClk(1);
      total++; if (msec !== 7'd1) begin bad++; $display("[TB] FAIL resume_phase1 got=%0d want=1", msec); end
      waitClk(1);
      total++; if (msec !== 7'd2) begin bad++; $display("[TB] FAIL resume_phase2 got=%0d want=2", msec); end
      pulseRun();
   endtask

   task automatic test_down_from_zero();
      int dones;
      doReset();
      dir = 1'b1;
      pulseRun();
      total++; if (running !== 1'b0) begin bad++; $display("[TB] FAIL zero_start got run=%b want=0", running); end
      dones = 0;
      for (int i = 0; i < 10; i++) begin
         waitClk(1);
         dones += int'(done) + int'(expired) + int'(running);
      end
      total++; if (dones !== 0) begin bad++; $display("[TB] FAIL zero_no_done got=%0d want=0", dones); end
      dir = 1'b0;
   endtask

   initial begin
      total = 0;
      bad = 0;
      test_reset();
      test_count_up_second();
      test_full_rollover();
      test_countdown_expire();
      test_adjust_on_tick();
      test_down_borrow();
      test_clear_and_reset();
      test_stop_resume();
      test_down_from_zero();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
